// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle for digit_serial_adder. Both sides use valid/ready:
// a transfer happens on a posedge where valid and ready are both high.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  // Handshake: the producer raises valid and holds its payload stable until
  // the edge where ready is also high. Ready never depends on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy, dbg_state
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy, dbg_state
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin computed DIGIT bits per clock
// through one registered DIGIT-wide adder, LSB digit first.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic              clk,
  input logic              rst,
  digit_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] sum_next;

  // One digit of the ripple chain; the carry into the digit's top bit is
  // recovered from the sum bit so ovf needs no separate chain.
  always_comb begin
    dsum  = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, carry};
    c_msb = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
    last  = (cnt == CW'(N - 1));
  end

  // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
  always_comb begin
    sum_next                    = sum_sr >> DIGIT;
    sum_next[WIDTH-1 -: DIGIT]  = dsum[DIGIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          sum_sr <= sum_next;
          carry  <= dsum[DIGIT];
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Published result only changes here, so it survives hand-off.
            sum_q  <= sum_next;
            cout_q <= dsum[DIGIT];
            ovf_q  <= c_msb ^ dsum[DIGIT];
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomised checks of digit_serial_adder at WIDTH=16, DIGIT=4.
module tb_digit_serial_adder;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int W     = WIDTH + 2;
  localparam int OPS   = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];

  digit_serial_adder_if #(.WIDTH(WIDTH)) bus();
  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y,
                                         input logic c);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {full[WIDTH], v, full[WIDTH-1:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.dbg_state} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b ov=%b busy=%b st=%0d want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.dbg_state);
    end
    total++;
    if ({bus.cout, bus.ovf, bus.sum} !== {W{1'b0}}) begin
      bad++;
      $display("FAIL reset_data: got %h want %h", {bus.cout, bus.ovf, bus.sum}, {W{1'b0}});
    end
    rst = 1'b0;
  endtask

  // driver: one operation with latency and hand-off checks; expected {cout,ovf,sum}
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_c, input logic [W-1:0] expv, input string name);
    int lat;
    logic [W-1:0] e;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got %b want 1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.a        = op_a;
    bus.b        = op_b;
    bus.cin      = op_c;
    exp_q.push_back(expv);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.cin      = 1'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != N) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, N);
    end
    e = exp_q.pop_front();
    total++;
    if ({bus.cout, bus.ovf, bus.sum} !== e) begin
      bad++;
      $display("FAIL %s_result: got %h want %h", name, {bus.cout, bus.ovf, bus.sum}, e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_handoff: got ov=%b rdy=%b want 0 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    run_op(16'h0000, 16'h0000, 1'b0, {1'b0, 1'b0, 16'h0000}, "zero");
    run_op(16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000}, "wrap");
    run_op(16'h1234, 16'h4321, 1'b1, {1'b0, 1'b0, 16'h5556}, "cin");
  endtask

  task automatic test_overflow();
    run_op(16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000}, "ovf_pos");
    run_op(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000}, "ovf_neg");
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'h0003;
    bus.b        = 16'h0004;
    bus.cin      = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != N) begin
      bad++;
      $display("FAIL bp_latency: got %0d want %0d", lat, N);
    end
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = 1'b1;
      bus.a         = 16'hFFFF;
      bus.b         = 16'hFFFF;
      bus.out_ready = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.in_ready, bus.cout, bus.ovf, bus.sum} !== {2'b10, 2'b00, 16'h0008}) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b rdy=%b res=%h want 1 0 %h", i,
                 bus.out_valid, bus.in_ready, {bus.cout, bus.ovf, bus.sum}, {2'b00, 16'h0008});
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.sum} !== {3'b010, 16'h0008}) begin
      bad++;
      $display("FAIL bp_release: got ov=%b rdy=%b busy=%b sum=%h want 0 1 0 0008",
               bus.out_valid, bus.in_ready, bus.busy, bus.sum);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL bp_ignored: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.sum} !== {3'b100, 2'b00, 16'h0000}) begin
      bad++;
      $display("FAIL midrst_state: got rdy=%b ov=%b busy=%b res=%h want 1 0 0 00000",
               bus.in_ready, bus.out_valid, bus.busy, {bus.cout, bus.ovf, bus.sum});
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen);
    end
    run_op(16'h00FF, 16'h0F01, 1'b0, {1'b0, 1'b0, 16'h1000}, "after_rst");
  endtask

  // in_valid and out_ready held high: results must be N+2 cycles apart
  task automatic test_back_to_back();
    int cyc;
    int hits[$];
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0102;
    bus.b         = 16'h0304;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (hits.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid === 1'b1) begin
        hits.push_back(cyc);
        total++;
        if ({bus.cout, bus.ovf, bus.sum} !== {2'b00, 16'h0406}) begin
          bad++;
          $display("FAIL b2b_result: got %h want %h", {bus.cout, bus.ovf, bus.sum}, {2'b00, 16'h0406});
        end
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (hits.size() != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d results want 3", hits.size());
    end else begin
      total++;
      if (hits[0] != N + 1 || hits[1] - hits[0] != N + 2 || hits[2] - hits[1] != N + 2) begin
        bad++;
        $display("FAIL b2b_spacing: got %0d %0d %0d want %0d %0d %0d",
                 hits[0], hits[1], hits[2], N + 1, 2 * N + 3, 3 * N + 5);
      end
    end
  endtask

  task automatic test_random();
    int sent;
    int got;
    int guard;
    logic acc;
    logic [W-1:0] e;
    sent = 0;
    got  = 0;
    guard = 0;
    acc  = 1'b0;
    while (got < OPS && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (!(bus.in_valid && !acc)) begin
        if (sent < OPS && $urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.a        = WIDTH'($urandom);
          bus.b        = WIDTH'($urandom);
          bus.cin      = 1'($urandom_range(0, 1));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      if (acc) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin));
        sent++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'bx}};
        got++;
        total++;
        if ({bus.cout, bus.ovf, bus.sum} !== e) begin
          bad++;
          $display("FAIL rand_op%0d: got %h want %h", got, {bus.cout, bus.ovf, bus.sum}, e);
        end
      end
    end
    idle_inputs();
    total++;
    if (got != OPS || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: got %0d results, %0d pending want %0d, 0", got, exp_q.size(), OPS);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
